// File: rtl/fir_l3_serializer.sv
// Buffers 3-sample FIR output blocks in a circular FIFO and emits them one sample per
// transfer on a valid/ready stream, oldest sample (y2) first.
module fir_l3_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           blk_valid,
  input  logic [DATA_WIDTH-1:0]          y0,
  input  logic [DATA_WIDTH-1:0]          y1,
  input  logic [DATA_WIDTH-1:0]          y2,
  input  logic                           clear,
  output logic [DATA_WIDTH-1:0]          s_data,
  output logic                           s_valid,
  input  logic                           s_ready,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           overflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned BlkW = 3 * DATA_WIDTH;

  logic [BlkW-1:0]       mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [1:0]            phase_q, phase_d;
  logic                  overflow_q, overflow_d;

  logic                  full, xfer, pop, push, wr_en;
  logic [BlkW-1:0]       head;
  logic [DATA_WIDTH-1:0] sel;

  always_comb begin
    full  = (count_q == CntW'(DEPTH));
    xfer  = (count_q != '0) && s_ready;
    pop   = xfer && (phase_q == 2'd2);
    // A full buffer still accepts a block when the head leaves in the same cycle.
    push  = blk_valid && (!full || pop);
    wr_en = push && !clear;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    phase_d    = phase_q;
    overflow_d = overflow_q;

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      phase_d    = 2'd0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
      if (xfer) phase_d = pop ? 2'd0 : phase_q + 2'd1;
      if (blk_valid && !push) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      phase_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  // Block storage carries no reset; occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {y2, y1, y0};
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    case (phase_q)
      2'd0:    sel = head[3*DATA_WIDTH-1:2*DATA_WIDTH];
      2'd1:    sel = head[2*DATA_WIDTH-1:DATA_WIDTH];
      default: sel = head[DATA_WIDTH-1:0];
    endcase
    s_valid  = (count_q != '0);
    s_data   = s_valid ? sel : '0;
    level    = count_q;
    overflow = overflow_q;
  end

endmodule

// File: doc/fir_l3_serializer.md
FIR_L3_SERIALIZER -- requirements
Module: fir_l3_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each filter output sample.
REQ-002 Parameter DEPTH, default 4: number of 3-sample blocks buffered; power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active low.
REQ-005 blk_valid  input  1  a new block on y0/y1/y2 this cycle; no back-pressure toward the source.
REQ-006 y0  input  DATA_WIDTH  signed, newest sample of the block.
REQ-007 y1  input  DATA_WIDTH  signed, middle sample of the block.
REQ-008 y2  input  DATA_WIDTH  signed, oldest sample of the block.
REQ-009 clear  input  1  synchronous flush of buffer, phase and overflow flag.
REQ-010 s_data  output  DATA_WIDTH  signed serial output sample.
REQ-011 s_valid  output  1  s_data holds a valid sample.
REQ-012 s_ready  input  1  downstream accepts s_data this cycle.
REQ-013 level  output  clog2(DEPTH+1)  number of blocks currently buffered, including a partially emitted one.
REQ-014 overflow  output  1  sticky: at least one block was dropped.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries, each holding {y2,y1,y0}, with write pointer, read pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-016 A block SHALL be written when blk_valid=1 and (count<DEPTH, or count=DEPTH with a pop in the same cycle).
REQ-017 When blk_valid=1, count=DEPTH and no pop occurs, the block SHALL be discarded, buffer unchanged, overflow set to 1.
REQ-018 A 2-bit phase counter SHALL select the head-block sample: phase 0 -> y2, 1 -> y1, 2 -> y0 (oldest first); value 3 is unreachable.
REQ-019 s_valid SHALL equal (count != 0); s_data SHALL be the head-block sample selected by phase, and 0 when count=0.
REQ-020 Transfer occurs on a cycle with s_valid=1 and s_ready=1; phase SHALL then advance by 1.
REQ-021 A transfer at phase 2 SHALL pop the head block (read pointer +1, count -1) and return phase to 0.
REQ-022 While s_valid=1 and s_ready=0, s_data, phase and the head block SHALL stay stable.
REQ-023 Simultaneous write and pop SHALL leave count unchanged and advance both pointers.
REQ-024 Latency: a block written into an empty buffer at edge N SHALL give s_valid=1 with its y2 on s_data after edge N; with s_ready held 1, y1 follows after edge N+1 and y0 after edge N+2.
REQ-025 Sustained blk_valid rate <= 1 per 3 cycles with s_ready=1 SHALL never overflow.
REQ-026 clear=1 SHALL, at the next edge, set count, pointers and phase to 0 and overflow to 0; a blk_valid in the same cycle is ignored; clear has priority over all other updates.
REQ-027 level SHALL equal count; it never exceeds DEPTH.
REQ-028 Samples SHALL pass bit-exact; no arithmetic, rounding or saturation is performed.

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk, set count, pointers and phase to 0, overflow=0, s_valid=0, s_data=0, level=0.
REQ-030 Reset asserted mid-block SHALL discard the partially emitted block; after release the first output is y2 of the next block written.
REQ-031 Buffer data contents need not be reset.

Verification
REQ-032 Single block {y2,y1,y0}={0x0003,0x0002,0x0001} with s_ready=1 -> s_data 0x0003,0x0002,0x0001 on three consecutive cycles, then s_valid=0, level 1->0.
REQ-033 DEPTH=4, s_ready=0, 5 blocks -> level=4, overflow=1 after the 5th; draining yields exactly the first 4 blocks in order (12 samples).
REQ-034 Full buffer, s_ready=1 at phase 2 together with blk_valid -> block accepted, level stays 4, overflow stays 0.
REQ-035 s_ready toggled 1,0,0,1,... during emission of {0x8000,0x7FFF,0xFFFF} -> each value held while stalled, none skipped or duplicated.
REQ-036 clear asserted with 3 blocks buffered, phase 1, overflow=1 -> next cycle level=0, s_valid=0, overflow=0; next block emits from y2.
REQ-037 rst_n pulsed low between edges with 2 blocks buffered -> outputs zero immediately; after release first output is y2 of a fresh block.
